// File: rtl/sump_pkg.sv
// sump_pkg: shared definitions for the SUMP host-side UART link.
// Holds the SUMP opcode constants, the long-command flag position, the
// TX/RX state encodings and two small lane-mask helpers used by word assembly.
package sump_pkg;

  localparam logic [7:0] SUMP_RESET    = 8'h00;
  localparam logic [7:0] SUMP_RUN      = 8'h01;
  localparam logic [7:0] SUMP_ID       = 8'h02;
  localparam logic [7:0] SUMP_METADATA = 8'h04;

  // Opcodes with this bit set carry a 32-bit argument (five bytes on the wire).
  localparam int SUMP_LONG_BIT = 7;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // An all-zero keep mask would never complete a word, so it means "all lanes".
  function automatic logic [3:0] effective_keep(input logic [3:0] keep);
    return (keep == 4'h0) ? 4'hF : keep;
  endfunction

  // Index of the lowest set bit; lanes fill in ascending order.
  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lane = 2'(i);
    end
    return lane;
  endfunction

endpackage

// File: rtl/sump_host_if.sv
// sump_host_if: command and response bus of the SUMP host.
//   cmd_opcode/cmd_data/cmd_valid -> host, cmd_ready <- host : command handshake
//   rd_keep -> host                                          : byte-lane mask of returned samples
//   rsp_data/rsp_valid <- host                               : assembled sample words
//   rx_err <- host                                           : framing-error strobe
// master: the user of the host (issues commands). slave: sump_host itself.
interface sump_host_if;

  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  rd_keep;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rx_err;

  modport master (
    output cmd_opcode, cmd_data, cmd_valid, rd_keep,
    input  cmd_ready, rsp_data, rsp_valid, rx_err
  );

  modport slave (
    input  cmd_opcode, cmd_data, cmd_valid, rd_keep,
    output cmd_ready, rsp_data, rsp_valid, rx_err
  );

endinterface

// File: rtl/sump_host_rx.sv
// sump_host_rx: 8N1 byte receiver for the SUMP host.
//   clk, rst    : system clock, asynchronous active-high reset
//   rx          : serial input, asynchronous to clk
//   byte_data   : last received byte (valid while byte_valid is high)
//   byte_valid  : one-cycle strobe, good stop bit seen
//   frame_err   : one-cycle strobe, stop bit sampled low (byte discarded)
// The line is double-synchronised; a falling edge starts a frame, which is
// confirmed half a bit later and then sampled at every bit centre.
module sump_host_rx
  import sump_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(DIV);
  // Explicit terminal counts keep non-power-of-two DIV from wrapping early.
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  assign byte_data = shift;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain the synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        RX_IDLE: begin
          // Edge rather than level, so a line still low after a bad stop
          // bit does not immediately open another frame.
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end

        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= RX_IDLE;       // glitch, not a start bit
            end else begin
              state   <= RX_DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};   // LSB arrives first
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sump_host.sv
// sump_host: host-side end of the analyzer UART link.
//   clk, rst   : system clock, asynchronous active-high reset
//   bus        : command handshake, keep mask, sample words, framing-error strobe
//   uart_tx    : 8N1 serial out, idle high (SUMP commands: 1 or 5 bytes)
//   uart_rx    : 8N1 serial in, asynchronous (returned sample bytes)
// FREQ/BAUD set the bit period DIV = FREQ/BAUD (rounded down, at least 4).
// TX and RX run fully independently, so uart_tx may be looped to uart_rx.
module sump_host
  import sump_pkg::*;
#(
  parameter int FREQ = 50_000_000,
  parameter int BAUD = 921_600
) (
  input  logic        clk,
  input  logic        rst,
  sump_host_if.slave  bus,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int DIV = FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

  // ---------------------------------------------------------------- TX path
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;   // byte on the wire, shifted right per data bit
  logic [31:0]   tx_rest;    // argument bytes still to send, next in [7:0]
  logic [2:0]    tx_left;    // bytes of the command not yet finished
  logic          accept;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= 3'd0;
      tx_shift      <= 8'h00;
      tx_rest       <= 32'h0;
      tx_left       <= 3'd0;
      uart_tx       <= 1'b1;
      bus.cmd_ready <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (accept) begin
            tx_state      <= TX_START;
            tx_cnt        <= '0;
            tx_shift      <= bus.cmd_opcode;
            tx_rest       <= bus.cmd_data;
            tx_left       <= bus.cmd_opcode[SUMP_LONG_BIT] ? 3'd5 : 3'd1;
            uart_tx       <= 1'b0;
            bus.cmd_ready <= 1'b0;
          end
        end

        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_state <= TX_DATA;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_left > 3'd1) begin
              // Next argument byte follows the stop bit with no idle gap.
              tx_state <= TX_START;
              tx_left  <= tx_left - 3'd1;
              tx_shift <= tx_rest[7:0];
              tx_rest  <= {8'h00, tx_rest[31:8]};
              uart_tx  <= 1'b0;
            end else begin
              tx_state      <= TX_IDLE;
              bus.cmd_ready <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_frame_err;

  sump_host_rx #(
    .DIV (DIV)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .byte_data  (rx_byte),
    .byte_valid (rx_byte_valid),
    .frame_err  (rx_frame_err)
  );

  // pending holds the lanes of the current word still to be filled; zero
  // means no word is open, so the next byte latches a fresh keep mask.
  logic [3:0]  pending;
  logic [31:0] word_buf;
  logic [3:0]  lane_mask;
  logic [1:0]  lane;
  logic [31:0] word_next;
  logic [3:0]  pending_next;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    lane_mask    = (pending == 4'h0) ? effective_keep(bus.rd_keep) : pending;
    lane         = lowest_lane(lane_mask);
    word_next    = word_buf;
    word_next[8*lane +: 8] = rx_byte;
    pending_next = lane_mask & ~(4'b0001 << lane);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= 4'h0;
      word_buf      <= 32'h0;
      bus.rsp_data  <= 32'h0;
      bus.rsp_valid <= 1'b0;
      bus.rx_err    <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rx_err    <= rx_frame_err;   // bad byte dropped, word state untouched
      if (rx_byte_valid) begin
        if (pending_next == 4'h0) begin
          bus.rsp_data  <= word_next;
          bus.rsp_valid <= 1'b1;
          word_buf      <= 32'h0;      // unkept lanes of the next word read as zero
          pending       <= 4'h0;
        end else begin
          word_buf <= word_next;
          pending  <= pending_next;
        end
      end
    end
  end

endmodule

// File: doc/sump_host.md
# sump_host

Host-side end of the analyzer's UART link, the counterpart to the core-side `uart` block. It encodes SUMP commands into 8N1 serial frames on `uart_tx`: one byte for short opcodes, five bytes for long opcodes. It decodes sample bytes returned on `uart_rx` into 32-bit words according to a byte-lane keep mask. It serves on-FPGA self-test and loopback of the analyzer, and acts as a bus-functional host in system benches.

## Interface
- `FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 921_600, serial bit rate. Bit period `DIV = FREQ/BAUD`, integer division rounded down; `DIV` must be at least 4.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_opcode`  in  8  SUMP opcode. Bit 7 set means a long command.
- `cmd_data`  in  32  long-command argument; ignored for short opcodes.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  transmitter idle; the command is accepted when `cmd_valid && cmd_ready`.
- `rd_keep`  in  4  enabled byte lanes of each returned sample. `4'h0` is treated as `4'hF`.
- `rsp_data`  out  32  assembled sample word.
- `rsp_valid`  out  1  one-cycle strobe, `rsp_data` valid. No backpressure.
- `rx_err`  out  1  one-cycle strobe on a framing error.
- `uart_tx`  out  1  serial out, idle high.
- `uart_rx`  in  1  serial in, asynchronous to `clk`.

## Operation
- **Reset values:** `uart_tx`=1, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rx_err`=0. Reset aborts any frame or partial word in progress.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE→START on accept. On accept, latch opcode and data and set the byte count: 5 if `cmd_opcode[7]`, else 1.
  - Byte order: opcode first, then `cmd_data[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
  - Each byte is sent as a start bit (0), 8 data bits LSB first, then a stop bit (1).
  - STOP→START with no idle gap while bytes remain; otherwise STOP→IDLE.
- **`cmd_ready`** is low in every state except IDLE. `cmd_valid` while not ready has no effect; the offerer must hold the command.
- **RX path:** `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge in RX idle starts a frame.
  - Half-bit check: if the line is high at `DIV/2`, the start is false; return to idle, no error.
  - Data bits are sampled at bit centres, i.e. every `DIV` cycles after the half-bit point.
  - Stop bit sampled at its centre. If it is 0: pulse `rx_err` and discard the byte. The lane position is unchanged and the partial word is kept.
- **Word assembly:**
  - Lane mask K = `rd_keep`, with 0 mapped to F, latched when the first byte of a word arrives.
  - Received bytes fill set lanes of K in ascending lane order. Lanes not in K are zero.
  - When the last set lane is filled, `rsp_data` takes the word and `rsp_valid` pulses, then the word restarts.
  - A `rd_keep` change mid-word takes effect from the next word.
- TX and RX are fully independent; simultaneous activity is required to work. A loopback with `uart_tx` tied to `uart_rx` must return each transmitted byte.

## Timing
- `uart_tx` falls on the first clock edge after accept. Each bit lasts exactly `DIV` cycles.
- Short command: 10·`DIV` cycles. Long command: 50·`DIV` cycles.
- `cmd_ready` rises on the edge that ends the last stop bit. A back-to-back accept on that cycle starts the next start bit with no gap.
- `rx_err` fires on the edge after the stop-bit sample. `rsp_valid` fires on the edge after the stop-bit sample of the word's final byte.
- Latency from the falling edge of the `uart_rx` start bit to the first data sample is 2 + `DIV/2` + `DIV` cycles (±1 for synchronizer phase).
- Bit counters are sized `$clog2(DIV)`. They must not wrap early when `DIV` is not a power of two.

## Structure
- Package `sump_pkg` holds:
  - opcode constants `SUMP_RESET`=8'h00, `SUMP_RUN`=8'h01, `SUMP_ID`=8'h02, `SUMP_METADATA`=8'h04;
  - `SUMP_LONG_BIT`=7;
  - typedef enums `tx_state_t` and `rx_state_t`.
- One sub-module, `sump_host_rx`: synchronizer, byte receiver and framing check. It outputs a byte plus a strobe. Word assembly and the TX path stay in `sump_host`.

## Test plan
All scenarios use `FREQ`=1_600_000 and `BAUD`=100_000, so `DIV`=16.
1. **Short command:** opcode 8'h01. `uart_tx` shows 0,1,0,0,0,0,0,0,0,1, each bit 16 cycles. `cmd_ready` is low for exactly 160 cycles.
2. **Long command:** opcode 8'h80, data 32'h12345678. Bytes 80,78,56,34,12 go out back-to-back in 800 cycles. A second `cmd_valid` during transmission is not accepted until `cmd_ready` rises.
3. **Full-word RX:** `rd_keep`=4'hF, bytes AA,BB,CC,DD. One `rsp_valid`, `rsp_data`=32'hDDCCBBAA.
4. **Sparse RX:** `rd_keep`=4'b0101, bytes 11,22. `rsp_data`=32'h00220011.
5. **Framing error and glitch:** byte 55 with its stop bit low gives `rx_err`=1 for one cycle and no lane advance. A following AA,BB,CC,DD yields 32'hDDCCBBAA. A 3-cycle low glitch on `uart_rx` produces no byte and no error.
6. **Reset mid-command:** `rst` asserted after 200 cycles of a long command. `uart_tx`=1 and `cmd_ready`=1 immediately. After release, a loopback run of opcode 8'h02 returns byte 02 on the RX side.
